// File: rtl/kb_event_scheduler.sv
// kb_event_scheduler: turns the PS/2 scan-code byte stream into a held-key
// bitmap for the ten game keys and a FIFO of press/release edges.
// Typematic repeats and E0-prefixed sequences are filtered out here, so the
// game FSM only ever sees real key transitions.
module kb_event_scheduler #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_frame_valid,
  input  logic [7:0]                    i_frame_data,
  output logic [9:0]                    o_key_status,
  output logic                          o_evt_valid,
  output logic [3:0]                    o_evt_key,
  output logic                          o_evt_press,
  input  logic                          i_evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  localparam logic [7:0] BYTE_BREAK = 8'hF0;
  localparam logic [7:0] BYTE_EXT   = 8'hE0;

  // Parser states
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_BREAK     = 2'd1;
  localparam logic [1:0] ST_EXT       = 2'd2;
  localparam logic [1:0] ST_EXT_BREAK = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [9:0]    status_q, status_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          key_hit;
  logic [3:0]    key_idx;
  logic          push;
  logic [3:0]    push_key;
  logic          push_press;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic [4:0]    head;

  // Event storage: {key[3:0], press}; contents need no reset because the
  // head fields are masked whenever the queue is empty.
  logic [4:0]    mem [FIFO_DEPTH];

  // Map the incoming byte onto a game-key index (bit position in the status map)
  always_comb begin
    key_hit = 1'b1;
    key_idx = 4'd0;
    case (i_frame_data)
      8'h1D:   key_idx = 4'd0;  // W
      8'h1B:   key_idx = 4'd1;  // S
      8'h1C:   key_idx = 4'd2;  // A
      8'h23:   key_idx = 4'd3;  // D
      8'h43:   key_idx = 4'd4;  // I
      8'h42:   key_idx = 4'd5;  // K
      8'h3B:   key_idx = 4'd6;  // J
      8'h4B:   key_idx = 4'd7;  // L
      8'h29:   key_idx = 4'd8;  // SPACE
      8'h5A:   key_idx = 4'd9;  // ENTER
      default: key_hit = 1'b0;
    endcase
  end

  // Prefix parser: tracks F0/E0 context, updates held-key map, requests pushes
  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    push       = 1'b0;
    push_key   = key_idx;
    push_press = 1'b0;
    if (i_frame_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (i_frame_data == BYTE_BREAK) begin
            state_d = ST_BREAK;
          end else if (i_frame_data == BYTE_EXT) begin
            state_d = ST_EXT;
          end else if (key_hit && !status_q[key_idx]) begin
            // First make of a released key; repeats while held are typematic
            status_d[key_idx] = 1'b1;
            push              = 1'b1;
            push_press        = 1'b1;
          end
        end
        ST_BREAK: begin
          if (i_frame_data == BYTE_BREAK) begin
            state_d = ST_BREAK;
          end else if (i_frame_data == BYTE_EXT) begin
            state_d = ST_EXT;
          end else begin
            state_d = ST_IDLE;
            if (key_hit && status_q[key_idx]) begin
              status_d[key_idx] = 1'b0;
              push              = 1'b1;
              push_press        = 1'b0;
            end
          end
        end
        ST_EXT: begin
          // Extended codes are never game keys (E0 5A is keypad Enter)
          state_d = (i_frame_data == BYTE_BREAK) ? ST_EXT_BREAK : ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Queue bookkeeping: a pop frees a slot in the same cycle a full push uses it
  always_comb begin
    pop        = o_evt_valid & i_evt_ready;
    full       = (count_q == FULL_COUNT);
    wr_en      = push & (~full | pop);
    overflow_d = overflow_q | (push & full & ~pop);
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(wr_en) - CW'(pop);
  end

  // Event storage write port
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= {push_key, push_press};
    end
  end

  // Control and status registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      status_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // First-word-fall-through head, forced to zero while the queue is empty
  always_comb begin
    head         = mem[rd_ptr_q];
    o_evt_valid  = (count_q != '0);
    o_evt_key    = o_evt_valid ? head[4:1] : 4'd0;
    o_evt_press  = o_evt_valid ? head[0]   : 1'b0;
    o_key_status = status_q;
    o_fifo_count = count_q;
    o_overflow   = overflow_q;
  end

endmodule

// File: doc/kb_event_scheduler.md
# kb_event_scheduler

Single-clock keyboard event controller placed between the PS/2 frame receiver and the game logic. It parses the scan-code byte stream and maintains a level-accurate pressed/released status for the ten game keys. Press and release edges are queued in a FIFO that the game FSM drains with a valid/ready handshake. Typematic repeats are suppressed, extended (E0) sequences are discarded, and queue overflow is flagged.

## Interface
- FIFO_DEPTH, 8, event queue depth; power of two, 2..32
- i_clk  in  1  system clock; all logic on posedge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_frame_valid  in  1  one-cycle pulse: a complete PS/2 byte is on i_frame_data; already synchronous to i_clk
- i_frame_data  in  8  received scan-code byte
- o_key_status  out  10  1 = key held; bit map W0 S1 A2 D3 I4 K5 J6 L7 SPACE8 ENTER9
- o_evt_valid  out  1  queue head valid
- o_evt_key  out  4  queue head key index 0..9
- o_evt_press  out  1  queue head kind: 1 press, 0 release
- i_evt_ready  in  1  consumer accepts head when high with o_evt_valid
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  entries queued
- o_overflow  out  1  sticky: an event was dropped

## Operation
- Key codes: W 1D, S 1B, A 1C, D 23, I 43, K 42, J 3B, L 4B, SPACE 29, ENTER 5A. Break prefix F0; extended prefix E0.
- The parser FSM advances only on cycles with i_frame_valid = 1. States and transitions:
  - IDLE: F0 → BREAK. E0 → EXT. Mapped code → make handling, stay IDLE. Any other byte → ignored.
  - BREAK: F0 → stay BREAK. E0 → EXT. Mapped code → break handling, then IDLE. Any other byte → IDLE.
  - EXT: F0 → EXT_BREAK. Any other byte → IDLE. The byte is discarded, so E0 5A (keypad Enter) never counts as ENTER.
  - EXT_BREAK: any byte → IDLE, discarded.
- Make handling, key k:
  - If status[k] = 0: set status[k], push {k, press = 1}.
  - If status[k] = 1: typematic repeat, no push, no change.
- Break handling, key k:
  - If status[k] = 1: clear status[k], push {k, press = 0}.
  - If status[k] = 0: no push.
- Every queued press has exactly one later matching release, unless an overflow drop breaks the pairing.
- FIFO behaviour:
  - First-word-fall-through, circular buffer. Read and write pointers wrap modulo FIFO_DEPTH.
  - Pop occurs when o_evt_valid & i_evt_ready.
  - Push when not full: accepted.
  - Push when full and pop in the same cycle: both performed; count unchanged.
  - Push when full and no pop: event dropped, o_overflow set. o_key_status is still updated.
  - Pop when empty: ignored.
- o_overflow clears only on reset.

## Timing
- Reset, asynchronous, takes effect immediately:
  - Parser state IDLE.
  - o_key_status = 0, o_evt_valid = 0, o_fifo_count = 0, o_overflow = 0.
  - o_evt_key and o_evt_press = 0.
  - Both FIFO pointers = 0.
- Reset mid-sequence (e.g. after F0) loses the pending prefix. The next byte is parsed from IDLE.
- Frame on posedge n → o_key_status updated and visible after posedge n.
- The pushed event raises o_evt_valid after the same edge n when the queue was empty. Latency is 1 cycle from the frame pulse.
- o_fifo_count reflects all pushes and pops of edge n after edge n.
- Head fields hold stable while o_evt_valid = 1 and i_evt_ready = 0.
- After a pop the next entry appears at the following edge. Sustained throughput is one event per cycle.
- i_frame_valid pulses are never closer than 2 cycles apart (PS/2 byte rate). Back-to-back pulses must still be parsed correctly.

## Test plan
- Reset, then frames 1D, F0, 1D, with i_evt_ready held 1:
  - Events {0, press} then {0, release}.
  - o_key_status[0] goes 1 then 0.
  - o_fifo_count returns to 0.
- Frames 43, 43, 43 (typematic), then F0 43:
  - Exactly two events: {4, press}, {4, release}.
  - Status bit 4 is 1 between them.
- Frames E0 5A, E0 F0 5A, then 5A:
  - Only one event {9, press}.
  - o_key_status = 10'h200.
- FIFO_DEPTH = 8, i_evt_ready = 0, alternating make/break of W, A, S, D, I, K, J, L, SPACE (18 events):
  - o_fifo_count saturates at 8; o_overflow = 1.
  - Drained order matches the first 8 events.
  - o_key_status reflects all 18 events.
- Full queue, push and pop in the same cycle: count stays 8, o_overflow unchanged, new event appears at the tail.
- Assert i_rst_n = 0 after byte F0, release, then frame 29:
  - Parsed as a make: {8, press}.
  - All outputs were 0 during reset.
